// File: rtl/adsr_pkg.sv
// Shared types and constants for the ADSR envelope / VCA slice.
package adsr_pkg;

    localparam int unsigned DATA_W         = 16;
    localparam int unsigned RATE_W         = 8;
    localparam int unsigned STEP_W         = 17;
    localparam int unsigned MULT_CYCLES    = 16;
    localparam int unsigned CNT_W          = 5;
    localparam int unsigned STEP_SHIFT_DEF = 4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ATTACK  = 3'd1,
        ST_DECAY   = 3'd2,
        ST_SUSTAIN = 3'd3,
        ST_RELEASE = 3'd4
    } adsr_state_e;

    // Envelope increment for a rate code: (rate + 1) << shift.
    function automatic logic [STEP_W-1:0] env_step(input logic [RATE_W-1:0] rate,
                                                   input int unsigned       shift);
        env_step = (STEP_W'(rate) + STEP_W'(1)) << shift;
    endfunction

endpackage

// File: rtl/adsr_vca_if.sv
// Control, audio and status signals between the voice controller and the ADSR/VCA.
// The release rate is named release_rate because 'release' is a reserved word.
interface adsr_vca_if;
    import adsr_pkg::*;

    logic              sample_en;
    logic              gate;
    logic [RATE_W-1:0] attack;
    logic [RATE_W-1:0] decay;
    logic [RATE_W-1:0] release_rate;
    logic [RATE_W-1:0] sustain;
    logic [DATA_W-1:0] din;
    logic [DATA_W-1:0] dout;
    logic              dout_valid;
    logic [DATA_W-1:0] env;
    logic              active;

    modport master (
        output sample_en, gate, attack, decay, release_rate, sustain, din,
        input  dout, dout_valid, env, active
    );

    modport slave (
        input  sample_en, gate, attack, decay, release_rate, sustain, din,
        output dout, dout_valid, env, active
    );

endinterface

// File: rtl/vca_mult16.sv
// Sequential 16x16 shift-add multiplier returning the upper 16 product bits.
// Result and done are registered 17 clocks after the accepted start.
module vca_mult16
    import adsr_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              done,
    output logic [DATA_W-1:0] result
);

    logic                  busy;
    logic [CNT_W-1:0]      cnt;
    logic [2*DATA_W-1:0]   acc;
    logic [2*DATA_W-1:0]   mcand;
    logic [DATA_W-1:0]     mplier;

    // Accept start only when idle, iterate 16 times, then publish the result.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else begin
            done <= 1'b0;
            if (!busy) begin
                if (start) begin
                    busy   <= 1'b1;
                    cnt    <= '0;
                    acc    <= '0;
                    mcand  <= (2*DATA_W)'(a);
                    mplier <= b;
                end
            end else if (cnt != CNT_W'(MULT_CYCLES)) begin
                if (mplier[0]) begin
                    acc <= acc + mcand;
                end
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt + CNT_W'(1);
            end else begin
                busy   <= 1'b0;
                done   <= 1'b1;
                result <= acc[2*DATA_W-1:DATA_W];
            end
        end
    end

endmodule

// File: rtl/adsr_vca.sv
// ADSR envelope generator driving a sequential VCA multiplier.
module adsr_vca
    import adsr_pkg::*;
#(
    parameter int unsigned STEP_SHIFT = STEP_SHIFT_DEF
) (
    input  logic       clk,
    input  logic       rst,
    adsr_vca_if.slave  bus
);

    adsr_state_e       state_q, state_n;
    logic [DATA_W-1:0] env_q, env_n;
    logic              gate_prev_q;
    logic              active_q;

    logic [STEP_W-1:0] atk_step, dec_step, rel_step;
    logic [DATA_W-1:0] s_lvl;
    logic [STEP_W:0]   atk_sum, dec_floor;
    logic              mult_done;
    logic [DATA_W-1:0] mult_result;

    assign atk_step  = env_step(bus.attack, STEP_SHIFT);
    assign dec_step  = env_step(bus.decay, STEP_SHIFT);
    assign rel_step  = env_step(bus.release_rate, STEP_SHIFT);
    assign s_lvl     = {bus.sustain, bus.sustain};
    assign atk_sum   = (STEP_W+1)'(env_q) + (STEP_W+1)'(atk_step);
    assign dec_floor = (STEP_W+1)'(s_lvl) + (STEP_W+1)'(dec_step);

    // Envelope state register; only sample ticks advance it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            env_q       <= '0;
            gate_prev_q <= 1'b0;
            active_q    <= 1'b0;
        end else if (bus.sample_en) begin
            state_q     <= state_n;
            env_q       <= env_n;
            gate_prev_q <= bus.gate;
            active_q    <= (state_n != ST_IDLE);
        end
    end

    // Next state and envelope: gate edge, gate release, then per-state step.
    always_comb begin
        state_n = state_q;
        env_n   = env_q;
        if (bus.gate && !gate_prev_q) begin
            state_n = ST_ATTACK;
        end else if (!bus.gate && (state_q == ST_ATTACK || state_q == ST_DECAY ||
                                   state_q == ST_SUSTAIN)) begin
            state_n = ST_RELEASE;
        end else begin
            case (state_q)
                ST_ATTACK: begin
                    if (atk_sum >= (STEP_W+1)'(16'hFFFF)) begin
                        env_n   = 16'hFFFF;
                        state_n = ST_DECAY;
                    end else begin
                        env_n = atk_sum[DATA_W-1:0];
                    end
                end
                ST_DECAY: begin
                    if ((STEP_W+1)'(env_q) <= dec_floor) begin
                        env_n   = s_lvl;
                        state_n = ST_SUSTAIN;
                    end else begin
                        env_n = env_q - dec_step[DATA_W-1:0];
                    end
                end
                ST_SUSTAIN: env_n = s_lvl;
                ST_RELEASE: begin
                    if (STEP_W'(env_q) <= rel_step) begin
                        env_n   = '0;
                        state_n = ST_IDLE;
                    end else begin
                        env_n = env_q - rel_step[DATA_W-1:0];
                    end
                end
                default: begin
                    env_n   = '0;
                    state_n = ST_IDLE;
                end
            endcase
        end
    end

    // The multiplier sees the envelope value from before this tick's update.
    vca_mult16 u_mult (
        .clk    (clk),
        .rst    (rst),
        .start  (bus.sample_en),
        .a      (bus.din),
        .b      (env_q),
        .done   (mult_done),
        .result (mult_result)
    );

    assign bus.dout       = mult_result;
    assign bus.dout_valid = mult_done;
    assign bus.env        = env_q;
    assign bus.active     = active_q;

endmodule

// File: tb/tb_adsr_vca.sv
// Directed self-checking bench for adsr_vca.
module tb_adsr_vca;
    import adsr_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    adsr_vca_if bus();

    adsr_vca #(.STEP_SHIFT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          n_cmp = 0;
    int          n_fail = 0;
    bit          seen;
    int          lat;
    int          vc;
    logic [15:0] dv;

    // One sample tick with din, then watch 20 cycles for the multiplier output.
    task automatic tick(input logic [15:0] d_in, output bit s, output int l,
                        output int c, output logic [15:0] d);
        s = 1'b0; l = 0; c = 0; d = '0;
        @(negedge clk);
        bus.din       = d_in;
        bus.sample_en = 1'b1;
        @(negedge clk);
        bus.sample_en = 1'b0;
        bus.din       = ~d_in;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (bus.dout_valid === 1'b1) begin
                if (!s) begin
                    s = 1'b1;
                    l = n;
                    d = bus.dout;
                end
                c++;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.sample_en = 1'b0; bus.gate = 1'b0; bus.din = '0;
        bus.attack = 8'hFF; bus.decay = 8'hFF; bus.release_rate = 8'hFF; bus.sustain = 8'h80;
        repeat (3) @(negedge clk);
        n_cmp++; if (bus.env !== 16'h0) begin n_fail++; $display("FAIL reset_env got %h want 0000", bus.env); end
        n_cmp++; if (bus.active !== 1'b0) begin n_fail++; $display("FAIL reset_active got %b want 0", bus.active); end
        n_cmp++; if (bus.dout !== 16'h0) begin n_fail++; $display("FAIL reset_dout got %h want 0000", bus.dout); end
        n_cmp++; if (bus.dout_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", bus.dout_valid); end
        n_cmp++; if (dut.state_q !== ST_IDLE) begin n_fail++; $display("FAIL reset_state got %0d want 0", dut.state_q); end
        rst = 1'b0;
    endtask

    task automatic test_idle();
        bus.gate = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick(16'h1234, seen, lat, vc, dv);
            n_cmp++; if (bus.env !== 16'h0) begin n_fail++; $display("FAIL idle_env k=%0d got %h want 0000", k, bus.env); end
            n_cmp++; if (bus.active !== 1'b0) begin n_fail++; $display("FAIL idle_active k=%0d got %b want 0", k, bus.active); end
            n_cmp++; if (lat != 17) begin n_fail++; $display("FAIL idle_latency k=%0d got %0d want 17", k, lat); end
            n_cmp++; if (dv !== 16'h0) begin n_fail++; $display("FAIL idle_dout k=%0d got %h want 0000", k, dv); end
        end
    endtask

    task automatic test_attack();
        logic [15:0] exp_env;
        bus.attack = 8'hFF; bus.decay = 8'hFF; bus.sustain = 8'h80; bus.release_rate = 8'hFF;
        bus.gate = 1'b1;
        tick(16'h8000, seen, lat, vc, dv);
        n_cmp++; if (bus.env !== 16'h0) begin n_fail++; $display("FAIL attack_trigger_env got %h want 0000", bus.env); end
        n_cmp++; if (bus.active !== 1'b1) begin n_fail++; $display("FAIL attack_active got %b want 1", bus.active); end
        for (int k = 1; k <= 16; k++) begin
            tick(16'h8000, seen, lat, vc, dv);
            exp_env = (k == 16) ? 16'hFFFF : 16'(k * 4096);
            n_cmp++; if (bus.env !== exp_env) begin n_fail++; $display("FAIL attack_env k=%0d got %h want %h", k, bus.env, exp_env); end
        end
        n_cmp++; if (dut.state_q !== ST_DECAY) begin n_fail++; $display("FAIL attack_to_decay got %0d want 2", dut.state_q); end
    endtask

    task automatic test_multiply();
        tick(16'h8000, seen, lat, vc, dv);
        n_cmp++; if (lat != 17) begin n_fail++; $display("FAIL mult_latency got %0d want 17", lat); end
        n_cmp++; if (vc != 1) begin n_fail++; $display("FAIL mult_pulse_len got %0d want 1", vc); end
        n_cmp++; if (dv !== 16'h7FFF) begin n_fail++; $display("FAIL mult_dout got %h want 7fff", dv); end
        n_cmp++; if (bus.env !== 16'hEFFF) begin n_fail++; $display("FAIL decay_env k=1 got %h want efff", bus.env); end
    endtask

    task automatic test_decay();
        logic [15:0] prev;
        logic [15:0] exp_env;
        prev = 16'hEFFF;
        for (int k = 2; k <= 8; k++) begin
            tick(16'hFFFF, seen, lat, vc, dv);
            exp_env = (k == 8) ? 16'h8080 : 16'(32'hFFFF - k * 4096);
            n_cmp++; if (bus.env !== exp_env) begin n_fail++; $display("FAIL decay_env k=%0d got %h want %h", k, bus.env, exp_env); end
            n_cmp++; if (dv !== prev - 16'd1) begin n_fail++; $display("FAIL decay_dout k=%0d got %h want %h", k, dv, prev - 16'd1); end
            if (k == 7) begin
                n_cmp++; if (dut.state_q !== ST_DECAY) begin n_fail++; $display("FAIL decay_state k=7 got %0d want 2", dut.state_q); end
            end
            prev = exp_env;
        end
        n_cmp++; if (dut.state_q !== ST_SUSTAIN) begin n_fail++; $display("FAIL decay_to_sustain got %0d want 3", dut.state_q); end
    endtask

    task automatic test_sustain();
        bus.sustain = 8'h40;
        tick(16'h0, seen, lat, vc, dv);
        n_cmp++; if (bus.env !== 16'h4040) begin n_fail++; $display("FAIL sustain_env_40 got %h want 4040", bus.env); end
        bus.sustain = 8'h80;
        tick(16'h0, seen, lat, vc, dv);
        n_cmp++; if (bus.env !== 16'h8080) begin n_fail++; $display("FAIL sustain_env_80 got %h want 8080", bus.env); end
        n_cmp++; if (dut.state_q !== ST_SUSTAIN) begin n_fail++; $display("FAIL sustain_state got %0d want 3", dut.state_q); end
    endtask

    task automatic test_retrigger();
        bus.release_rate = 8'h80;
        bus.gate = 1'b0;
        tick(16'h0, seen, lat, vc, dv);
        n_cmp++; if (dut.state_q !== ST_RELEASE) begin n_fail++; $display("FAIL rel_enter_state got %0d want 4", dut.state_q); end
        n_cmp++; if (bus.env !== 16'h8080) begin n_fail++; $display("FAIL rel_enter_env got %h want 8080", bus.env); end
        for (int k = 1; k <= 8; k++) begin
            tick(16'h0, seen, lat, vc, dv);
            if (k == 1) begin
                n_cmp++; if (bus.env !== 16'h7870) begin n_fail++; $display("FAIL rel_env k=1 got %h want 7870", bus.env); end
            end
        end
        n_cmp++; if (bus.env !== 16'h4000) begin n_fail++; $display("FAIL rel_env k=8 got %h want 4000", bus.env); end
        bus.gate = 1'b1;
        tick(16'h0, seen, lat, vc, dv);
        n_cmp++; if (dut.state_q !== ST_ATTACK) begin n_fail++; $display("FAIL retrig_state got %0d want 1", dut.state_q); end
        n_cmp++; if (bus.env !== 16'h4000) begin n_fail++; $display("FAIL retrig_env_held got %h want 4000", bus.env); end
        tick(16'h0, seen, lat, vc, dv);
        n_cmp++; if (bus.env !== 16'h5000) begin n_fail++; $display("FAIL retrig_env_step got %h want 5000", bus.env); end
    endtask

    task automatic test_gate_off_decay();
        for (int k = 1; k <= 11; k++) tick(16'h0, seen, lat, vc, dv);
        n_cmp++; if (bus.env !== 16'hFFFF) begin n_fail++; $display("FAIL reattack_env got %h want ffff", bus.env); end
        tick(16'h0, seen, lat, vc, dv);
        n_cmp++; if (dut.state_q !== ST_DECAY) begin n_fail++; $display("FAIL redecay_state got %0d want 2", dut.state_q); end
        bus.gate = 1'b0;
        bus.release_rate = 8'hFF;
        tick(16'h0, seen, lat, vc, dv);
        n_cmp++; if (dut.state_q !== ST_RELEASE) begin n_fail++; $display("FAIL decay_gate_off_state got %0d want 4", dut.state_q); end
        n_cmp++; if (bus.env !== 16'hEFFF) begin n_fail++; $display("FAIL decay_gate_off_env got %h want efff", bus.env); end
        for (int k = 1; k <= 14; k++) tick(16'h0, seen, lat, vc, dv);
        n_cmp++; if (bus.env !== 16'h0FFF) begin n_fail++; $display("FAIL rel_near_zero got %h want 0fff", bus.env); end
        tick(16'h0, seen, lat, vc, dv);
        n_cmp++; if (bus.env !== 16'h0) begin n_fail++; $display("FAIL rel_floor_env got %h want 0000", bus.env); end
        n_cmp++; if (dut.state_q !== ST_IDLE) begin n_fail++; $display("FAIL rel_to_idle got %0d want 0", dut.state_q); end
        n_cmp++; if (bus.active !== 1'b0) begin n_fail++; $display("FAIL rel_active got %b want 0", bus.active); end
    endtask

    task automatic test_back_to_back();
        int first_lat;
        int count;
        logic [15:0] first_d;
        bus.gate = 1'b1;
        tick(16'h0, seen, lat, vc, dv);
        tick(16'h0, seen, lat, vc, dv);
        first_lat = 0; count = 0; first_d = '0;
        @(negedge clk);
        bus.din = 16'hFFFF;
        bus.sample_en = 1'b1;
        @(negedge clk);
        bus.sample_en = 1'b0;
        bus.din = 16'h0;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            bus.sample_en = (n == 5);
            if (bus.dout_valid === 1'b1) begin
                if (count == 0) begin first_lat = n; first_d = bus.dout; end
                count++;
            end
        end
        n_cmp++; if (count != 1) begin n_fail++; $display("FAIL overlap_pulses got %0d want 1", count); end
        n_cmp++; if (first_lat != 17) begin n_fail++; $display("FAIL overlap_latency got %0d want 17", first_lat); end
        n_cmp++; if (first_d !== 16'h0FFF) begin n_fail++; $display("FAIL overlap_dout got %h want 0fff", first_d); end
        n_cmp++; if (bus.env !== 16'h3000) begin n_fail++; $display("FAIL overlap_env got %h want 3000", bus.env); end
    endtask

    task automatic test_reset_mid_mult();
        int count;
        count = 0;
        @(negedge clk);
        bus.din = 16'h8000;
        bus.sample_en = 1'b1;
        @(negedge clk);
        bus.sample_en = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (bus.dout_valid === 1'b1) count++;
        end
        n_cmp++; if (count != 0) begin n_fail++; $display("FAIL abort_valid got %0d pulses want 0", count); end
        n_cmp++; if (bus.dout !== 16'h0) begin n_fail++; $display("FAIL abort_dout got %h want 0000", bus.dout); end
        n_cmp++; if (bus.env !== 16'h0) begin n_fail++; $display("FAIL abort_env got %h want 0000", bus.env); end
        n_cmp++; if (bus.active !== 1'b0) begin n_fail++; $display("FAIL abort_active got %b want 0", bus.active); end
        tick(16'h8000, seen, lat, vc, dv);
        n_cmp++; if (dut.state_q !== ST_ATTACK) begin n_fail++; $display("FAIL post_reset_trigger got %0d want 1", dut.state_q); end
        n_cmp++; if (bus.env !== 16'h0) begin n_fail++; $display("FAIL post_reset_env got %h want 0000", bus.env); end
        n_cmp++; if (lat != 17) begin n_fail++; $display("FAIL post_reset_latency got %0d want 17", lat); end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_attack();
        test_multiply();
        test_decay();
        test_sustain();
        test_retrigger();
        test_gate_off_decay();
        test_back_to_back();
        test_reset_mid_mult();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
